// File: rtl/regfile_wb_pkg.sv
// Shared types for the regfile writeback block.
// Optional forwarding lookup is enabled with macro REGFILE_WB_FWD_EN.
package regfile_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // One queued multdiv result; live=0 marks an entry that must not reach the regfile.
  typedef struct packed {
    logic                  live;
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_squash_fifo.sv
// wb_squash_fifo: circular queue of multdiv results with a squash port that
// clears the live bit of every stored entry targeting a given register.
// With REGFILE_WB_FWD_EN the raw storage and read pointer are exported for lookup.
module wb_squash_fifo
  import regfile_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  input  logic                  squash_valid,
  input  logic [ADDR_W_DEF-1:0] squash_reg,
  output wb_entry_t             head,
  output logic [CNT_W-1:0]      count
`ifdef REGFILE_WB_FWD_EN
  ,
  output wb_entry_t             entries [DEPTH],
  output logic [PTR_W-1:0]      rd_ptr
`endif
);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage: squash stored entries, then write the pushed entry (its live bit is pre-filtered).
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (squash_valid && (r_mem[i].rd == squash_reg)) r_mem[i].live <= 1'b0;
    end
    if (push) r_mem[r_wr_ptr] <= push_entry;
  end

  // Pointers wrap naturally at DEPTH; occupancy alone decides full/empty.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
`ifdef REGFILE_WB_FWD_EN
  assign entries = r_mem;
  assign rd_ptr  = r_rd_ptr;
`endif

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: sole driver of the regfile write port. ALU results win
// every cycle; multdiv results wait in a squashing queue and drain when the ALU
// is idle. Macro REGFILE_WB_FWD_EN adds a two-port combinational forwarding lookup.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int ADDR_W     = ADDR_W_DEF,
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_reg,
  input  logic [DATA_W-1:0] md_data,
  output logic              ctrl_writeEn,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic [CNT_W-1:0]  md_count
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] fwd_regA,
  input  logic [ADDR_W-1:0] fwd_regB,
  output logic              fwd_hitA,
  output logic              fwd_hitB,
  output logic [DATA_W-1:0] fwd_dataA,
  output logic [DATA_W-1:0] fwd_dataB
`endif
);

  logic             w_alu_wr;
  logic             w_push;
  logic             w_pop;
  wb_entry_t        w_push_entry;
  wb_entry_t        w_head;
  logic [CNT_W-1:0] w_count;
`ifdef REGFILE_WB_FWD_EN
  wb_entry_t        w_entries [FIFO_DEPTH];
  logic [PTR_W-1:0] w_rd_ptr;
`endif

  // An ALU write to r0 is consumed without preempting the queue.
  assign w_alu_wr = alu_valid && (alu_reg != '0);
  // Readiness depends only on registered occupancy, never on a same-cycle pop.
  assign md_ready = ctrl_reset && (w_count < CNT_W'(FIFO_DEPTH));
  assign w_push   = md_valid && md_ready;
  assign w_pop    = !w_alu_wr && (w_count != '0);
  assign md_count = w_count;

  // A push to r0, or to the register the ALU writes this cycle, is born dead.
  assign w_push_entry.live = (md_reg != '0) && !(w_alu_wr && (alu_reg == md_reg));
  assign w_push_entry.rd   = md_reg;
  assign w_push_entry.data = md_data;

  wb_squash_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .push         (w_push),
    .push_entry   (w_push_entry),
    .pop          (w_pop),
    .squash_valid (w_alu_wr),
    .squash_reg   (alu_reg),
    .head         (w_head),
    .count        (w_count)
`ifdef REGFILE_WB_FWD_EN
    ,
    .entries      (w_entries),
    .rd_ptr       (w_rd_ptr)
`endif
  );

  // Output stage: ALU first, then queue head (dead heads are dropped), else idle with held index/data.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      ctrl_writeEn  <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
    end else if (w_alu_wr) begin
      ctrl_writeEn  <= 1'b1;
      ctrl_writeReg <= alu_reg;
      data_writeReg <= alu_data;
    end else if (w_pop) begin
      ctrl_writeEn <= w_head.live;
      if (w_head.live) begin
        ctrl_writeReg <= w_head.rd;
        data_writeReg <= w_head.data;
      end
    end else begin
      ctrl_writeEn <= 1'b0;
    end
  end

`ifdef REGFILE_WB_FWD_EN
  // Forwarding: scan oldest to youngest so the youngest live match wins; the output register overrides.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    w_idx     = '0;
    fwd_hitA  = 1'b0;
    fwd_dataA = '0;
    fwd_hitB  = 1'b0;
    fwd_dataB = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CNT_W'(i) < w_count) begin
        w_idx = w_rd_ptr + PTR_W'(i);
        if (w_entries[w_idx].live && (w_entries[w_idx].rd == fwd_regA) && (fwd_regA != '0)) begin
          fwd_hitA  = 1'b1;
          fwd_dataA = w_entries[w_idx].data;
        end
        if (w_entries[w_idx].live && (w_entries[w_idx].rd == fwd_regB) && (fwd_regB != '0)) begin
          fwd_hitB  = 1'b1;
          fwd_dataB = w_entries[w_idx].data;
        end
      end
    end
    if (ctrl_writeEn && (ctrl_writeReg == fwd_regA) && (fwd_regA != '0)) begin
      fwd_hitA  = 1'b1;
      fwd_dataA = data_writeReg;
    end
    if (ctrl_writeEn && (ctrl_writeReg == fwd_regB) && (fwd_regB != '0)) begin
      fwd_hitB  = 1'b1;
      fwd_dataB = data_writeReg;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_writeback;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [2:0]  md_count;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0]  fwd_regA;
  logic [4:0]  fwd_regB;
  logic        fwd_hitA;
  logic        fwd_hitB;
  logic [31:0] fwd_dataA;
  logic [31:0] fwd_dataB;
`endif

  regfile_writeback dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .alu_valid     (alu_valid),
    .alu_reg       (alu_reg),
    .alu_data      (alu_data),
    .md_valid      (md_valid),
    .md_ready      (md_ready),
    .md_reg        (md_reg),
    .md_data       (md_data),
    .ctrl_writeEn  (ctrl_writeEn),
    .ctrl_writeReg (ctrl_writeReg),
    .data_writeReg (data_writeReg),
    .md_count      (md_count)
`ifdef REGFILE_WB_FWD_EN
    ,
    .fwd_regA      (fwd_regA),
    .fwd_regB      (fwd_regB),
    .fwd_hitA      (fwd_hitA),
    .fwd_hitB      (fwd_hitB),
    .fwd_dataA     (fwd_dataA),
    .fwd_dataB     (fwd_dataB)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending results and the expected write port.
  typedef struct {
    bit          live;
    logic [4:0]  rd;
    logic [31:0] data;
  } m_ent_t;

  m_ent_t      q[$];
  bit          exp_we   = 1'b0;
  logic [4:0]  exp_reg  = '0;
  logic [31:0] exp_data = '0;
  logic [31:0] dut_rf [32];

  initial for (int i = 0; i < 32; i++) dut_rf[i] = '0;

  task automatic model_step();
    bit     alu_wr;
    bit     push;
    m_ent_t e;
    if (!ctrl_reset) begin
      q.delete();
      exp_we   = 1'b0;
      exp_reg  = '0;
      exp_data = '0;
    end else begin
      alu_wr = alu_valid && (alu_reg != 0);
      push   = md_valid && (q.size() < 4);
      if (alu_wr) begin
        foreach (q[i]) if (q[i].rd == alu_reg) q[i].live = 1'b0;
        exp_we   = 1'b1;
        exp_reg  = alu_reg;
        exp_data = alu_data;
      end else if (q.size() > 0) begin
        e      = q.pop_front();
        exp_we = e.live;
        if (e.live) begin
          exp_reg  = e.rd;
          exp_data = e.data;
        end
      end else begin
        exp_we = 1'b0;
      end
      if (push) begin
        e.live = (md_reg != 0) && !(alu_wr && (alu_reg == md_reg));
        e.rd   = md_reg;
        e.data = md_data;
        q.push_back(e);
      end
    end
  endtask

`ifdef REGFILE_WB_FWD_EN
  task automatic fwd_model(input logic [4:0] r, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (r != 0) begin
      foreach (q[i]) if (q[i].live && (q[i].rd == r)) begin
        hit = 1'b1;
        d   = q[i].data;
      end
      if (exp_we && (exp_reg == r)) begin
        hit = 1'b1;
        d   = exp_data;
      end
    end
  endtask
`endif

  // Advance the model on each edge, then compare the settled DUT outputs.
  always @(posedge clock) begin
    model_step();
    #2;
    check("writeEn", ctrl_writeEn, exp_we);
    if (exp_we) begin
      check("writeReg", ctrl_writeReg, exp_reg);
      check("writeData", data_writeReg, exp_data);
    end
    check("md_count", md_count, q.size());
    check("md_ready", md_ready, ctrl_reset && (q.size() < 4));
`ifdef REGFILE_WB_FWD_EN
    begin
      logic        h;
      logic [31:0] d;
      fwd_model(fwd_regA, h, d);
      check("fwd_hitA", fwd_hitA, h);
      if (h) check("fwd_dataA", fwd_dataA, d);
      fwd_model(fwd_regB, h, d);
      check("fwd_hitB", fwd_hitB, h);
      if (h) check("fwd_dataB", fwd_dataB, d);
    end
`endif
    if (ctrl_writeEn === 1'b1) dut_rf[ctrl_writeReg] = data_writeReg;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    ctrl_reset = 1'b0;
    alu_valid  = 1'b0;
    alu_reg    = '0;
    alu_data   = '0;
    md_valid   = 1'b1;
    md_reg     = 5'd4;
    md_data    = 32'h44;
`ifdef REGFILE_WB_FWD_EN
    fwd_regA   = '0;
    fwd_regB   = '0;
`endif

    // Reset held with md_valid asserted.
    repeat (2) begin
      tick();
      check("rst_ready", md_ready, 0);
      check("rst_we", ctrl_writeEn, 0);
      check("rst_count", md_count, 0);
    end
    ctrl_reset = 1'b1;
    md_valid   = 1'b0;
    tick();

    // Single ALU write.
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h0000DEAD;
    tick();
    check("alu_we", ctrl_writeEn, 1);
    check("alu_reg", ctrl_writeReg, 5);
    check("alu_data", data_writeReg, 32'h0000DEAD);
    alu_valid = 1'b0;
    tick();
    check("alu_idle_we", ctrl_writeEn, 0);
    check("rf_r5", dut_rf[5], 32'h0000DEAD);

    // Single multdiv result, ALU idle.
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h12345678;
    tick();
    check("md_push_count", md_count, 1);
    check("md_push_we", ctrl_writeEn, 0);
    md_valid = 1'b0;
    tick();
    check("md_we", ctrl_writeEn, 1);
    check("md_reg", ctrl_writeReg, 7);
    check("md_data", data_writeReg, 32'h12345678);
    check("md_drain_count", md_count, 0);

    // ALU busy every cycle while five multdiv pushes are offered.
    alu_valid = 1'b1; alu_reg = 5'd1; md_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      alu_data = 32'(k);
      md_reg   = 5'(10 + k);
      md_data  = 32'h100 + 32'(k);
      tick();
      check("fill_count", md_count, (k < 4) ? k + 1 : 4);
      check("fill_ready", md_ready, (k < 3) ? 1 : 0);
    end
    alu_valid = 1'b0; md_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_we", ctrl_writeEn, 1);
      check("drain_reg", ctrl_writeReg, 10 + k);
      check("drain_data", data_writeReg, 32'h100 + 32'(k));
    end
    check("drain_empty", md_count, 0);
    tick();
    check("rf_r13", dut_rf[13], 32'h103);

    // ALU write squashes an older queued result to the same register.
    md_valid = 1'b1; md_reg = 5'd9; md_data = 32'hAAAA;
    tick();
    md_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'hBBBB;
    tick();
    check("sq_we", ctrl_writeEn, 1);
    check("sq_data", data_writeReg, 32'hBBBB);
    check("sq_count", md_count, 1);
    alu_valid = 1'b0;
    tick();
    check("stale_we", ctrl_writeEn, 0);
    check("stale_count", md_count, 0);
    check("rf_r9", dut_rf[9], 32'hBBBB);

    // Same-cycle push and ALU write to one register.
    md_valid = 1'b1; md_reg = 5'd9; md_data = 32'hCCCC;
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'hDDDD;
    tick();
    check("same_we", ctrl_writeEn, 1);
    check("same_data", data_writeReg, 32'hDDDD);
    md_valid = 1'b0; alu_valid = 1'b0;
    tick();
    check("same_stale_we", ctrl_writeEn, 0);
    check("rf_r9b", dut_rf[9], 32'hDDDD);

    // Register 0 from both sources.
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF;
    md_valid = 1'b1; md_reg = 5'd0; md_data = 32'h1;
    tick();
    check("r0_we", ctrl_writeEn, 0);
    check("r0_count", md_count, 1);
    alu_valid = 1'b0; md_valid = 1'b0;
    tick();
    check("r0_pop_we", ctrl_writeEn, 0);
    check("r0_pop_count", md_count, 0);
    check("rf_r0", dut_rf[0], 0);

`ifdef REGFILE_WB_FWD_EN
    // Forwarding from the queue and from the output register.
    alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h11;
    md_valid = 1'b1; md_reg = 5'd3; md_data = 32'h3333;
    fwd_regA = 5'd3; fwd_regB = 5'd0;
    tick();
    check("fwdq_hitA", fwd_hitA, 1);
    check("fwdq_dataA", fwd_dataA, 32'h3333);
    check("fwd_r0_hitB", fwd_hitB, 0);
    md_valid = 1'b0; fwd_regB = 5'd1;
    #1;
    check("fwdo_hitB", fwd_hitB, 1);
    check("fwdo_dataB", fwd_dataB, 32'h11);
    fwd_regA = 5'd0;
    #1;
    check("fwd_r0_hitA", fwd_hitA, 0);
    fwd_regA = 5'd3;
    alu_valid = 1'b0;
    tick();
    check("fwd_pop_we", ctrl_writeEn, 1);
    check("fwd_pop_hitA", fwd_hitA, 1);
    check("fwd_pop_dataA", fwd_dataA, 32'h3333);
    check("fwd_pop_count", md_count, 0);
`endif

    // Reset in the middle of operation discards queued entries.
    alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 32'h22;
    md_valid = 1'b1; md_reg = 5'd20; md_data = 32'h20;
    tick();
    md_reg = 5'd21; md_data = 32'h21;
    tick();
    check("mid_count", md_count, 2);
    alu_valid = 1'b0; md_valid = 1'b0; ctrl_reset = 1'b0;
    tick();
    check("mid_rst_count", md_count, 0);
    check("mid_rst_we", ctrl_writeEn, 0);
    check("mid_rst_ready", md_ready, 0);
    ctrl_reset = 1'b1;
    repeat (2) begin
      tick();
      check("post_rst_we", ctrl_writeEn, 0);
      check("post_rst_count", md_count, 0);
    end
    check("rf_r20", dut_rf[20], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
